wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writer side of the register-file write port: merges writebacks from the single-cycle
//  primary path (ALU) and a long-latency secondary path (load/mul-div) into one registered
//  we/wa/wd stream for the regfile. Secondary results are buffered in a small FIFO.
//  Primary has priority; a stall counter guarantees forward progress for the secondary path.
// PARAMETERS
//  DEPTH      4   secondary FIFO entries (power of two, >=2)
//  MAX_STALL  8   cycles a non-empty FIFO head may lose arbitration before it is forced through
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  p_valid    in   1   primary writeback request
//  p_ready    out  1   primary accepted when p_valid&&p_ready
//  p_addr     in   5   primary destination register
//  p_data     in   32  primary write data
//  s_valid    in   1   secondary writeback request
//  s_ready    out  1   secondary accepted when s_valid&&s_ready
//  s_addr     in   5   secondary destination register
//  s_data     in   32  secondary write data
//  we         out  1   regfile write enable (registered)
//  wa         out  5   regfile write address (registered)
//  wd         out  32  regfile write data (registered)
//  fifo_cnt   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset: we=0, wa=0, wd=0, FIFO empty (fifo_cnt=0), stall counter=0, p_ready=1, s_ready=1.
//  - s_ready = (fifo_cnt != DEPTH); no pass-through: a full FIFO stays not-ready even if it
//    dequeues in the same cycle. Enqueue and dequeue in one cycle is legal when 0<cnt<DEPTH.
//  - p_ready = !force, where force = (stall_cnt == MAX_STALL) && FIFO non-empty.
//  - Grant per cycle: force -> FIFO head; else p_valid -> primary; else FIFO non-empty -> head;
//    else idle. Granted request loads we/wa/wd next edge (primary latency 1 cycle, secondary
//    minimum 2 cycles: enqueue edge, then dequeue edge). Idle cycle: we=0, wa/wd hold.
//  - Writes with addr==0 are accepted/dequeued normally but drive we=0 (dropped).
//  - stall_cnt: +1 each cycle FIFO non-empty and head not granted; cleared to 0 when head is
//    granted or FIFO empty; saturates at MAX_STALL.
//  - Ordering: in-order within each channel only; no WAW ordering between channels. Preventing
//    same-register conflicts between channels is the issue stage's job.
//  - Pointers wrap modulo DEPTH; fifo_cnt is exact from 0 to DEPTH.
//  - Reset asserted mid-operation: FIFO contents and any pending write are discarded; we=0
//    immediately (asynchronous).
// CONFIGURATION
//  WB_PENDING_EN defined: extra output pending[31:1] (31 bits). Bit r = 1 when any valid FIFO
//   entry, or the output stage with we=1, targets register r. Combinational from state; the
//   issue stage uses it to stall reads/writes of in-flight registers. Reset value 0.
//  WB_PENDING_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1 reset, no requests -> we=0, p_ready=1, s_ready=1, fifo_cnt=0 for 10 cycles
//  2 p_valid, p_addr=5, p_data=0xDEADBEEF -> next edge we=1, wa=5, wd=0xDEADBEEF
//  3 s_valid, s_addr=7, s_data=0x12, primary idle -> fifo_cnt=1 after edge 1; we=1,wa=7,wd=0x12
//    after edge 2; fifo_cnt=0
//  4 p_valid held every cycle, one secondary enqueued (addr 3) -> head loses MAX_STALL=8 cycles,
//    cycle 9 p_ready=0, secondary write to x3 issued, then primary resumes
//  5 fill FIFO with 4 secondary writes while primary busy -> s_ready=0 at fifo_cnt=4; 5th s_valid
//    held until a dequeue; all 5 written in enqueue order
//  6 p_addr=0 with p_valid -> p_ready=1, we stays 0; with WB_PENDING_EN, enqueue addr 9 ->
//    pending[9]=1 until write retires, then 0

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: primary path with priority, secondary FIFO with stall-forced drain
// Optional WB_PENDING_EN adds pending[31:1], the in-flight destination-register scoreboard.
module wb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int MAX_STALL = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p_valid,
  output logic                     p_ready,
  input  logic [4:0]               p_addr,
  input  logic [31:0]              p_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_addr,
  input  logic [31:0]              s_data,
  output logic                     we,
  output logic [4:0]               wa,
  output logic [31:0]              wd,
`ifdef WB_PENDING_EN
  output logic [31:1]              pending,
`endif
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_STALL + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [31:0]     wd_q, wd_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            force_head;
  logic            grant_p;
  logic            grant_s;
  logic            push;
  entry_t          head;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CW'(DEPTH));
    head       = mem_q[rd_ptr_q];
    // A head that has lost MAX_STALL arbitrations takes the port from the primary path.
    force_head = (stall_q == SW'(MAX_STALL)) && !fifo_empty;
    grant_p    = p_valid && !force_head;
    grant_s    = !fifo_empty && (force_head || !p_valid);
    // No pass-through: readiness depends only on occupancy, never on a same-cycle dequeue.
    push       = s_valid && !fifo_full;

    wr_ptr_d = push    ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = grant_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(grant_s);

    stall_d = stall_q;
    if (fifo_empty || grant_s) begin
      stall_d = '0;
    end else if (stall_q != SW'(MAX_STALL)) begin
      stall_d = stall_q + SW'(1);
    end

    // Register 0 writes are consumed like any other but never assert we.
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (grant_p) begin
      we_d = (p_addr != 5'd0);
      wa_d = p_addr;
      wd_d = p_data;
    end else if (grant_s) begin
      we_d = (head.addr != 5'd0);
      wa_d = head.addr;
      wd_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  // Entry storage needs no reset: only slots inside the occupancy window are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: s_addr, data: s_data};
    end
  end

  assign p_ready  = !force_head;
  assign s_ready  = !fifo_full;
  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign fifo_cnt = cnt_q;

`ifdef WB_PENDING_EN
  logic [31:1] pend_vec;
  entry_t      slot;

  always_comb begin
    pend_vec = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = mem_q[rd_ptr_q + AW'(k)];
      if ((CW'(k) < cnt_q) && (slot.addr != 5'd0)) begin
        pend_vec[slot.addr] = 1'b1;
      end
    end
    if (we_q && (wa_q != 5'd0)) begin
      pend_vec[wa_q] = 1'b1;
    end
  end

  assign pending = pend_vec;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed table-driven bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_valid;
  logic        p_ready;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  fifo_cnt;
`ifdef WB_PENDING_EN
  logic [31:1] pending;
`endif

  int n_total;
  int n_pass;

  wb_arbiter #(.DEPTH(4), .MAX_STALL(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
`ifdef WB_PENDING_EN
    .pending  (pending),
`endif
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        e_pr;
    logic        e_sr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        chk_wawd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    @(negedge clk);
    p_valid = pv; p_addr = pa; p_data = pd;
    s_valid = sv; s_addr = sa; s_data = sd;
    #1;
  endtask

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s_idx;
    int w_idx;
    logic acc;

    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    p_valid = 0; p_addr = 0; p_data = 0;
    s_valid = 0; s_addr = 0; s_data = 0;

    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h12, 1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 3'd1, 1'b1};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h12,       3'd0, 1'b1};
    vecs[4] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd3, 32'hA,  1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 3'd1, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3,  32'hA,        3'd0, 1'b1};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h99, 1'b1, 1'b1, 1'b0, 5'd3,  32'hA,        3'd1, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0};

    // Reset, then ten idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_wait();
      check("idle_we", 32'(we), 32'd0);
      check("idle_p_ready", 32'(p_ready), 32'd1);
      check("idle_s_ready", 32'(s_ready), 32'd1);
      check("idle_fifo_cnt", 32'(fifo_cnt), 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].sv, vecs[i].sa, vecs[i].sd);
      check($sformatf("vec%0d_p_ready", i), 32'(p_ready), 32'(vecs[i].e_pr));
      check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      edge_wait();
      check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_fifo_cnt", i), 32'(fifo_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_wawd) begin
        check($sformatf("vec%0d_wa", i), 32'(wa), 32'(vecs[i].e_wa));
        check($sformatf("vec%0d_wd", i), wd, vecs[i].e_wd);
      end
    end

    // Starvation guard: primary streams every cycle while one secondary waits.
    drive(1'b1, 5'd10, 32'd100, 1'b1, 5'd3, 32'h333);
    check("stall_c0_p_ready", 32'(p_ready), 32'd1);
    edge_wait();
    check("stall_c0_wa", 32'(wa), 32'd10);
    check("stall_c0_cnt", 32'(fifo_cnt), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 5'(10 + k), 32'(100 + k), 1'b0, 5'd0, 32'h0);
      check($sformatf("stall_c%0d_p_ready", k), 32'(p_ready), 32'd1);
      edge_wait();
      check($sformatf("stall_c%0d_wa", k), 32'(wa), 32'(10 + k));
      check($sformatf("stall_c%0d_cnt", k), 32'(fifo_cnt), 32'd1);
    end
    drive(1'b1, 5'd19, 32'd109, 1'b0, 5'd0, 32'h0);
    check("stall_c9_p_ready", 32'(p_ready), 32'd0);
    edge_wait();
    check("stall_c9_we", 32'(we), 32'd1);
    check("stall_c9_wa", 32'(wa), 32'd3);
    check("stall_c9_wd", wd, 32'h333);
    check("stall_c9_cnt", 32'(fifo_cnt), 32'd0);
    drive(1'b1, 5'd19, 32'd109, 1'b0, 5'd0, 32'h0);
    check("stall_c10_p_ready", 32'(p_ready), 32'd1);
    edge_wait();
    check("stall_c10_wa", 32'(wa), 32'd19);
    check("stall_c10_wd", wd, 32'd109);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge_wait();

    // Fill to full under primary pressure; a fifth request waits and order is preserved.
    s_idx = 0;
    w_idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive(cyc < 12, 5'd1, 32'(cyc), s_idx < 5, 5'(20 + s_idx), 32'(1000 + s_idx));
      if (cyc == 4) begin
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_fifo_cnt", 32'(fifo_cnt), 32'd4);
      end
      if (cyc == 9) begin
        check("full_force_p_ready", 32'(p_ready), 32'd0);
        check("full_no_passthru_s_ready", 32'(s_ready), 32'd0);
      end
      acc = s_valid && s_ready;
      edge_wait();
      if (acc) s_idx++;
      if (we && wa >= 5'd20 && wa <= 5'd24) begin
        check($sformatf("order_wa%0d", w_idx), 32'(wa), 32'(20 + w_idx));
        check($sformatf("order_wd%0d", w_idx), wd, 32'(1000 + w_idx));
        w_idx++;
      end
    end
    check("order_count", 32'(w_idx), 32'd5);
    check("order_drained_cnt", 32'(fifo_cnt), 32'd0);

`ifdef WB_PENDING_EN
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9);
    edge_wait();
    check("pend_queued", 32'(pending[9]), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge_wait();
    check("pend_out_we", 32'(we), 32'd1);
    check("pend_out_stage", 32'(pending[9]), 32'd1);
    edge_wait();
    check("pend_retired", 32'(pending[9]), 32'd0);
`endif

    // Asynchronous reset in the middle of traffic.
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    edge_wait();
    check("mid_pre_we", 32'(we), 32'd1);
    check("mid_pre_cnt", 32'(fifo_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    edge_wait();
    check("post_rst_we", 32'(we), 32'd0);
    check("post_rst_cnt", 32'(fifo_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
